ysyx_22041207_booth_mul: RTL
============================

// Module: ysyx_22041207_booth_mul
// PURPOSE
//  Multi-cycle 64x64 radix-4 Booth multiplier, directly downstream of the EX ALU.
//  The ALU issues operands a/b with a one-cycle valid pulse, then stalls the
//  pipeline (alu_wait) until out_valid. It reads {hi,lo} to form MUL/MULH/MULHSU/MULHU/MULW.
// PARAMETERS
//  XLEN        64  operand width; only 64 is supported
//  ITER_D      33  Booth iterations, 64-bit op: (XLEN+2)/2
//  ITER_W      17  Booth iterations, 32-bit op (mulw)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  mul_valid    in   1   request pulse; sampled only while mul_ready=1
//  flush        in   1   pipeline flush; aborts any operation
//  mulw         in   1   1 = 32-bit op on multiplicand[31:0], multiplier[31:0]
//  mul_signed   in   2   2'b11 s*s, 2'b10 s(a)*u(b), 2'b00 u*u; 2'b01 treated as 2'b00
//  multiplicand in   64  operand a
//  multiplier   in   64  operand b
//  mul_ready    out  1   1 only in IDLE
//  out_valid    out  1   result valid, exactly one cycle
//  result_hi    out  64  product[127:64]; 0 when mulw
//  result_lo    out  64  product[63:0]; sext(product[31:0]) when mulw
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, mul_ready=1, out_valid=0, result_hi/lo=0, count=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: mul_valid & ~flush -> latch operands and extend to 66 bits.
//         Sign-extend where signed; zero-extend otherwise.
//         mulw: low 32 bits extended to 34 bits.
//         Clear the 132-bit partial product. count=0. -> BUSY.
//   BUSY: each cycle examine 3 multiplier bits {b[2i+1],b[2i],b[2i-1]}, with b[-1]=0.
//         Add 0/+-A/+-2A to the upper partial product, then arithmetic-shift right by 2.
//         count++. After ITER_D (ITER_W if mulw) iterations -> DONE.
//   DONE: result_hi/lo registered from the partial product. out_valid=1 this cycle only. -> IDLE.
//  Latency: acceptance at edge N; out_valid high in the cycle after edge N+34.
//   mulw: after edge N+18. mul_ready=0 from edge N until return to IDLE.
//  result_hi/lo hold their last value until the next DONE (ALU may sample late).
//  Handshake: mul_valid while mul_ready=0 is ignored (no queueing).
//   No input is re-sampled during BUSY; operands live in internal registers.
//  flush: highest priority, any state.
//   Next edge -> IDLE, count=0, out_valid=0; result regs unchanged.
//   flush & mul_valid in IDLE: request dropped.
//   flush in DONE: the cycle's out_valid still shows. Next edge is IDLE.
//  Reset mid-operation: immediate IDLE, outputs to reset values, no out_valid.
//  Back-to-back: new request accepted in the first IDLE cycle after DONE.
//   Min issue interval 35 cycles (19 for mulw).
//  Widths: adder 66+2 bits wide on the upper slice. -2A formed as ~(A<<1)+1; no overflow lost.
// STRUCTURE
//  Shared package: MUL_SIGN_SS/SU/UU encodings, FSM state encodings, ITER_D/ITER_W.
//   Package goes alongside the ALU opcode defines.
//  One sub-module: ysyx_22041207_booth_sel.
//   Combinational: 3-bit Booth digit + 66-bit A -> 68-bit partial addend.
//  FSM, counter and accumulator stay in this module.
// TESTING
//  1) u*u 0xFFFF_FFFF_FFFF_FFFF * 2 -> hi=0x1, lo=0xFFFF_FFFF_FFFF_FFFE.
//     out_valid exactly 34 cycles after accept.
//  2) s*s -1 * -1 -> hi=0, lo=1.
//     s*s 0x8000_0000_0000_0000 * 0x8000_0000_0000_0000 -> hi=0x4000_0000_0000_0000, lo=0.
//  3) s*u -1 * 0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0x1.
//  4) mulw a=0x1_7FFF_FFFF, b=2 -> lo=0xFFFF_FFFF_FFFF_FFFE, hi=0. out_valid after 18 cycles.
//  5) flush at cycle 10 of BUSY -> no out_valid; mul_ready=1 next cycle.
//     New 3*5 then gives lo=15.
//  6) Extra mul_valid pulses during BUSY are ignored; result unchanged.
//     rst low mid-BUSY -> outputs 0, mul_ready=1 asynchronously.
//     Random 10k ops vs $signed/$unsigned 128-bit reference model.

Source files
------------

// File: rtl/ysyx_22041207_booth_mul_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: signedness encodings,
// FSM states, iteration counts and the operand-extension helper.
package ysyx_22041207_booth_mul_pkg;

    localparam int XLEN   = 64;
    localparam int EXT_W  = XLEN + 2;
    localparam int PP_W   = 2 * EXT_W;
    localparam int ADD_W  = EXT_W + 2;
    localparam int CNT_W  = 6;
    localparam int ITER_D = (XLEN + 2) / 2;
    localparam int ITER_W = 17;

    localparam logic [1:0] MUL_SIGN_SS = 2'b11;
    localparam logic [1:0] MUL_SIGN_SU = 2'b10;
    localparam logic [1:0] MUL_SIGN_UU = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // A 32-bit operand is first widened to 34 bits and then sign-extended to
    // the full datapath, which keeps its value intact for either signedness.
    function automatic logic [EXT_W-1:0] ext_operand(
        input logic [XLEN-1:0] v,
        input logic            is_signed,
        input logic            is_word
    );
        logic [33:0] w_v34;
        w_v34 = {{2{is_signed & v[31]}}, v[31:0]};
        if (is_word)
            return {{(EXT_W-34){w_v34[33]}}, w_v34};
        else
            return {{2{is_signed & v[XLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22041207_booth_sel.sv
// Radix-4 Booth digit decoder: maps a 3-bit multiplier window onto the
// addend 0, +-A or +-2A, sign-extended to the accumulator adder width.
module ysyx_22041207_booth_sel
    import ysyx_22041207_booth_mul_pkg::*;
(
    input  logic [2:0]       i_digit,
    input  logic [EXT_W-1:0] i_a,
    output logic [ADD_W-1:0] o_addend
);

    logic [ADD_W-1:0] w_a1;
    logic [ADD_W-1:0] w_a2;

    assign w_a1 = {{2{i_a[EXT_W-1]}}, i_a};
    assign w_a2 = {i_a[EXT_W-1], i_a, 1'b0};

    always_comb begin
        o_addend = '0;
        case (i_digit)
            3'b001, 3'b010: o_addend = w_a1;
            3'b011:         o_addend = w_a2;
            3'b100:         o_addend = ~w_a2 + {{(ADD_W-1){1'b0}}, 1'b1};
            3'b101, 3'b110: o_addend = ~w_a1 + {{(ADD_W-1){1'b0}}, 1'b1};
            default:        o_addend = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041207_booth_mul.sv
// Multi-cycle 64x64 radix-4 Booth multiplier feeding the EX ALU; one Booth
// digit per cycle, 33 iterations (17 for the 32-bit word form).
module ysyx_22041207_booth_mul
    import ysyx_22041207_booth_mul_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mul_valid,
    input  logic            i_flush,
    input  logic            i_mulw,
    input  logic [1:0]      i_mul_signed,
    input  logic [XLEN-1:0] i_multiplicand,
    input  logic [XLEN-1:0] i_multiplier,
    output logic            o_mul_ready,
    output logic            o_out_valid,
    output logic [XLEN-1:0] o_result_hi,
    output logic [XLEN-1:0] o_result_lo
);

    mul_state_e        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [EXT_W-1:0]  r_a;
    logic [PP_W-1:0]   r_pp;
    logic              r_bprev;
    logic              r_mulw;
    logic              r_mul_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result_hi;
    logic [XLEN-1:0]   r_result_lo;

    logic              w_a_signed;
    logic              w_b_signed;
    logic [2:0]        w_digit;
    logic [ADD_W-1:0]  w_addend;
    logic [ADD_W-1:0]  w_sum;
    logic [PP_W-1:0]   w_pp_next;
    logic [CNT_W-1:0]  w_last_iter;

    assign w_a_signed  = (i_mul_signed == MUL_SIGN_SS) || (i_mul_signed == MUL_SIGN_SU);
    assign w_b_signed  = (i_mul_signed == MUL_SIGN_SS);
    assign w_digit     = {r_pp[1:0], r_bprev};
    assign w_last_iter = r_mulw ? CNT_W'(ITER_W - 1) : CNT_W'(ITER_D - 1);

    ysyx_22041207_booth_sel u_booth_sel (
        .i_digit  (w_digit),
        .i_a      (r_a),
        .o_addend (w_addend)
    );

    // Upper slice gets two guard bits so +-2A never overflows; the 2-bit
    // arithmetic shift then drops them back into the 132-bit accumulator.
    assign w_sum     = {{2{r_pp[PP_W-1]}}, r_pp[PP_W-1:EXT_W]} + w_addend;
    assign w_pp_next = {w_sum, r_pp[EXT_W-1:2]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_a         <= '0;
            r_pp        <= '0;
            r_bprev     <= 1'b0;
            r_mulw      <= 1'b0;
            r_mul_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_result_hi <= '0;
            r_result_lo <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_mul_valid && !i_flush) begin
                        r_a         <= ext_operand(i_multiplicand, w_a_signed, i_mulw);
                        r_pp        <= {{EXT_W{1'b0}}, ext_operand(i_multiplier, w_b_signed, i_mulw)};
                        r_bprev     <= 1'b0;
                        r_mulw      <= i_mulw;
                        r_count     <= '0;
                        r_mul_ready <= 1'b0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        r_count     <= '0;
                        r_mul_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_pp    <= w_pp_next;
                        r_bprev <= r_pp[1];
                        r_count <= r_count + 1'b1;
                        if (r_count == w_last_iter)
                            r_state <= ST_DONE;
                    end
                end
                // A flush arriving here still lets the finished result out,
                // since the FSM returns to IDLE on this edge regardless.
                ST_DONE: begin
                    if (r_mulw) begin
                        r_result_hi <= '0;
                        r_result_lo <= {{32{r_pp[63]}}, r_pp[63:32]};
                    end else begin
                        r_result_hi <= r_pp[127:64];
                        r_result_lo <= r_pp[63:0];
                    end
                    r_out_valid <= 1'b1;
                    r_count     <= '0;
                    r_mul_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_count     <= '0;
                    r_mul_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mul_ready = r_mul_ready;
    assign o_out_valid = r_out_valid;
    assign o_result_hi = r_result_hi;
    assign o_result_lo = r_result_lo;

endmodule
